led_stack_fx: RTL and testbench

Parametrised LED "stacking" effect engine for the LED effect boards. A serial bit `s_in` enters at the top of a `WIDTH`-bit LED bar on each effect step. Lit bits fall toward the bottom and pile up on the contiguous stack already there. An internal prescaler sets the step rate, and a small FSM selects wrap or bounce (hold, then drain) behaviour once the bar is full. The block sits between the board's pattern/serial source and the LED output pins.

---
 rtl/led_stack_fx.sv | 152 +++++++++++++++
 tb/tb_led_stack_fx.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_stack_fx.sv
// LED stacking effect engine: serial bits fall down a WIDTH-bit bar onto a contiguous stack,
// with wrap or bounce (hold, then drain) once full. Define LED_STACK_CYCLE_CNT_EN for cycle_cnt.
module led_stack_fx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE   = 4,
  parameter int unsigned HOLD_STEPS = 3,
  parameter int unsigned REVERSE    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             mode,
  input  logic             s_in,
  output logic [WIDTH-1:0] q_out,
  output logic             step,
`ifdef LED_STACK_CYCLE_CNT_EN
  output logic [7:0]       cycle_cnt,
`endif
  output logic             full
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned HW = $clog2(HOLD_STEPS + 1);
  localparam logic [WIDTH-1:0] TopOnly = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

  typedef enum logic [1:0] {StFill, StHold, StDrain} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [HW-1:0]    hold_q, hold_d, hold_inc;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] stack_mask, fill_next, msb_bit;
  logic             full_q, full_d;
  logic             bar_full, bar_empty, hold_done;

  // Step strobe is combinational so the new pattern lands on the edge closing the strobe cycle.
  assign step = reset_n & en & (presc_q == '0);

  always_comb begin
    presc_d = presc_q;
    if (en) begin
      presc_d = (presc_q == '0) ? PW'(PRESCALE - 1) : presc_q - 1'b1;
    end
  end

  assign bar_full  = (pat_q == AllOnes);
  assign bar_empty = (pat_q == '0);
  assign hold_inc  = hold_q + 1'b1;
  assign hold_done = (32'(hold_inc) >= HOLD_STEPS);

  // stack_mask[i] is set when bits 0..i (logical, bottom up) are all lit.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      stack_mask[i] = &(pat_q | ~(AllOnes >> (WIDTH - 1 - i)));
    end
  end

  always_comb begin
    msb_bit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pat_q[i]) begin
        msb_bit    = '0;
        msb_bit[i] = 1'b1;
      end
    end
  end

  // Stack stays put; everything above falls one position; s_in enters at the top.
  assign fill_next = (pat_q & stack_mask)
                   | ({1'b0, pat_q[WIDTH-1:1]} & ~stack_mask)
                   | (s_in ? TopOnly : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (step) begin
      unique case (state_q)
        StFill:  if (bar_full && mode) state_d = StHold;
        StHold:  if (hold_done) state_d = StDrain;
        StDrain: if (bar_empty) state_d = StFill;
        default: state_d = StFill;
      endcase
    end
  end

  always_comb begin
    pat_d  = pat_q;
    hold_d = hold_q;
    full_d = 1'b0;
    if (step) begin
      unique case (state_q)
        StFill: begin
          if (bar_full) begin
            if (mode) hold_d = HW'(1);
            else      pat_d  = TopOnly;
          end else begin
            pat_d  = fill_next;
            full_d = (fill_next == AllOnes);
          end
        end
        StHold:  hold_d = hold_inc;
        StDrain: pat_d  = bar_empty ? TopOnly : (pat_q & ~msb_bit);
        default: pat_d  = TopOnly;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= PW'(PRESCALE - 1);
      hold_q  <= '0;
      pat_q   <= TopOnly;
      full_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hold_q  <= hold_d;
      pat_q   <= pat_d;
      full_q  <= full_d;
    end
  end

  assign full = full_q;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      q_out[i] = (REVERSE != 0) ? pat_q[WIDTH-1-i] : pat_q[i];
    end
  end

`ifdef LED_STACK_CYCLE_CNT_EN
  logic [7:0] cycle_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q <= 8'd0;
    end else if (full_d) begin
      cycle_q <= cycle_q + 8'd1;
    end
  end

  assign cycle_cnt = cycle_q;
`endif

endmodule

// File: tb/tb_led_stack_fx.sv
// Bench for led_stack_fx: two configurations checked every cycle against a behavioural model,
// plus directed sequences for fill, wrap, bounce, prescale/enable and asynchronous reset.
module tb_led_stack_fx;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       mode;
  logic       s_in;
  logic [7:0] q0;
  logic [3:0] q1;
  logic       step0, step1, full0, full1;
`ifdef LED_STACK_CYCLE_CNT_EN
  logic [7:0] cc0, cc1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int cfg_w[2] = '{8, 4};
  int cfg_p[2] = '{1, 4};
  int cfg_h[2] = '{3, 2};
  int cfg_r[2] = '{0, 1};

  // Model state per DUT, pattern kept in logical order (bottom = bit 0).
  logic [31:0] m_pat[2];
  int          m_cnt[2];
  int          m_phase[2];  // 0 fill, 1 hold, 2 drain
  int          m_hold[2];
  bit          m_full[2];
  int          m_cc[2];

  led_stack_fx #(.WIDTH(8), .PRESCALE(1), .HOLD_STEPS(3), .REVERSE(0)) u_dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .mode      (mode),
    .s_in      (s_in),
    .q_out     (q0),
    .step      (step0),
`ifdef LED_STACK_CYCLE_CNT_EN
    .cycle_cnt (cc0),
`endif
    .full      (full0)
  );

  led_stack_fx #(.WIDTH(4), .PRESCALE(4), .HOLD_STEPS(2), .REVERSE(1)) u_dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .mode      (mode),
    .s_in      (s_in),
    .q_out     (q1),
    .step      (step1),
`ifdef LED_STACK_CYCLE_CNT_EN
    .cycle_cnt (cc1),
`endif
    .full      (full1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] phys(input int k, input logic [31:0] lg);
    logic [31:0] o;
    o = lg;
    if (cfg_r[k] != 0) begin
      o = '0;
      for (int i = 0; i < cfg_w[k]; i++) o[i] = lg[cfg_w[k]-1-i];
    end
    return o;
  endfunction

  task automatic model_reset(input int k);
    m_pat[k]   = 32'd1 << (cfg_w[k] - 1);
    m_cnt[k]   = cfg_p[k] - 1;
    m_phase[k] = 0;
    m_hold[k]  = 0;
    m_full[k]  = 1'b0;
    m_cc[k]    = 0;
  endtask

  task automatic model_step(input int k);
    int w, h, m;
    logic [31:0] ones, top, r, n;
    w    = cfg_w[k];
    ones = 32'((64'd1 << w) - 64'd1);
    top  = 32'd1 << (w - 1);
    r    = m_pat[k];
    case (m_phase[k])
      0: begin
        if (r == ones) begin
          if (mode) begin
            m_phase[k] = 1;
            m_hold[k]  = 1;
          end else begin
            m_pat[k] = top;
          end
        end else begin
          h = 0;
          while (h < w && r[h]) h++;
          n = '0;
          for (int i = 0; i < w; i++) begin
            if (i < h)          n[i] = r[i];
            else if (i < w - 1) n[i] = r[i+1];
            else                n[i] = s_in;
          end
          m_pat[k]  = n;
          m_full[k] = (n == ones);
        end
      end
      1: begin
        m_hold[k]++;
        if (m_hold[k] >= cfg_h[k]) m_phase[k] = 2;
      end
      default: begin
        if (r == 0) begin
          m_pat[k]   = top;
          m_phase[k] = 0;
        end else begin
          m = w - 1;
          while (!r[m]) m--;
          n        = r;
          n[m]     = 1'b0;
          m_pat[k] = n;
        end
      end
    endcase
  endtask

  task automatic model_clock(input int k);
    m_full[k] = 1'b0;
    if (en) begin
      if (m_cnt[k] == 0) begin
        m_cnt[k] = cfg_p[k] - 1;
        model_step(k);
      end else begin
        m_cnt[k]--;
      end
    end
    m_cc[k] = (m_cc[k] + int'(m_full[k])) % 256;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Continuous model comparison on the falling edge.
  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        model_reset(0);
        model_reset(1);
        check_eq("rst_q0", 32'(q0), 32'h80);
        check_eq("rst_q1", 32'(q1), 32'h1);
        check_eq("rst_step", 32'({step0, step1}), 32'h0);
        check_eq("rst_full", 32'({full0, full1}), 32'h0);
      end else begin
        check_eq("q0", 32'(q0), phys(0, m_pat[0]));
        check_eq("step0", 32'(step0), 32'(en && (m_cnt[0] == 0)));
        check_eq("full0", 32'(full0), 32'(m_full[0]));
        check_eq("q1", 32'(q1), phys(1, m_pat[1]));
        check_eq("step1", 32'(step1), 32'(en && (m_cnt[1] == 0)));
        check_eq("full1", 32'(full1), 32'(m_full[1]));
`ifdef LED_STACK_CYCLE_CNT_EN
        check_eq("cc0", 32'(cc0), 32'(m_cc[0]));
        check_eq("cc1", 32'(cc1), 32'(m_cc[1]));
`endif
        model_clock(0);
        model_clock(1);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_step1(output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (step1) begin
        t = cyc;
        break;
      end
    end
  endtask

  logic [7:0] seq_wrap[9]  = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h80};
  logic [7:0] seq_fall[10] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                               8'h01, 8'h01};
  logic [7:0] seq_bnc[20]  = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                               8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07,
                               8'h03, 8'h01, 8'h00, 8'h80};

  initial begin
    int t0, t1, t2, polls;
    logic [3:0] saved;
    reset_n = 1'b0;
    en      = 1'b1;
    mode    = 1'b0;
    s_in    = 1'b1;

    // Wrap fill.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_eq("wrap_q", 32'(q0), 32'(seq_wrap[i]));
      check_eq("wrap_full", 32'(full0), 32'(i == 7));
    end

    // Falling bits with s_in low come to rest at the bottom.
    s_in = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("fall_q", 32'(q0), 32'(seq_fall[i]));
    end

    // Bounce: hold then drain.
    s_in = 1'b1;
    mode = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("bounce_q", 32'(q0), 32'(seq_bnc[i]));
      check_eq("bounce_full", 32'(full0), 32'(i == 7));
    end

    // Prescale timing and enable freeze on the 4-LED reversed instance.
    s_in = 1'b0;
    mode = 1'b0;
    do_reset();
    t0 = cyc;
    wait_step1(t1);
    check_eq("first_step", 32'(t1 - t0), 32'd3);
    @(posedge clk);
    #1 check_eq("rev_step_q1", 32'(q1), 32'h2);
    wait_step1(t1);
    wait_step1(t2);
    check_eq("step_gap", 32'(t2 - t1), 32'd4);
    @(posedge clk);
    #1 en = 1'b0;
    saved = q1;
    repeat (10) @(posedge clk);
    #1 check_eq("en_freeze_q1", 32'(q1), 32'(saved));
    en = 1'b1;
    wait_step1(t1);
    check_eq("en_gap", 32'(t1 - t2), 32'd14);

    // Asynchronous reset in the middle of a drain.
    s_in = 1'b1;
    mode = 1'b1;
    do_reset();
    polls = 0;
    while (!(m_phase[1] == 2 && m_pat[1] != 0) && polls < 200) begin
      @(posedge clk);
      #1 polls++;
    end
    check_eq("drain_reached", 32'(polls < 200), 32'd1);
    #1 reset_n = 1'b0;
    #1 check_eq("async_q1", 32'(q1), 32'h1);
    check_eq("async_q0", 32'(q0), 32'h80);
    @(posedge clk);
    #1 reset_n = 1'b1;

`ifdef LED_STACK_CYCLE_CNT_EN
    mode = 1'b0;
    s_in = 1'b1;
    do_reset();
    repeat (24) @(posedge clk);
    #1 check_eq("cc_three", 32'(cc0), 32'd3);
    repeat (256 * 8 - 24) @(posedge clk);
    #1 check_eq("cc_wrap", 32'(cc0), 32'd0);
`endif

    // Randomised run with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      en      = ($urandom_range(0, 3) != 0);
      s_in    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      reset_n = ($urandom_range(0, 499) != 0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
